// File: rtl/page_linker_if.sv
// Handshake bundle for page_linker: writer grant, packet report, release
// request and the null-page FIFO side. The slave view belongs to the linker.
interface page_linker_if #(
  parameter int PAGE_W = 11
);
  logic              wr_req;
  logic              wr_sop;
  logic              wr_eop;
  logic              wr_ack;
  logic [PAGE_W-1:0] wr_page;
  logic              pkt_valid;
  logic [PAGE_W-1:0] pkt_head;
  logic [PAGE_W:0]   pkt_len;
  logic              proto_err;
  logic              rel_req;
  logic [PAGE_W-1:0] rel_head;
  logic [PAGE_W:0]   rel_pages;
  logic              rel_ready;
  logic              rel_done;
  logic              pop_head;
  logic [PAGE_W-1:0] head_addr;
  logic              push_tail;
  logic [PAGE_W-1:0] tail_addr;
  logic [PAGE_W:0]   free_cnt;

  modport slave (
    input  wr_req, wr_sop, wr_eop, rel_req, rel_head, rel_pages, head_addr,
    output wr_ack, wr_page, pkt_valid, pkt_head, pkt_len, proto_err,
           rel_ready, rel_done, pop_head, push_tail, tail_addr, free_cnt
  );

  modport master (
    output wr_req, wr_sop, wr_eop, rel_req, rel_head, rel_pages, head_addr,
    input  wr_ack, wr_page, pkt_valid, pkt_head, pkt_len, proto_err,
           rel_ready, rel_done, pop_head, push_tail, tail_addr, free_cnt
  );
endinterface

// File: rtl/page_linker.sv
// Builds per-packet linked page chains from the null-page FIFO and walks
// released chains back into it. rst_n is an active-high synchronous reset.
//   state  | meaning
//   S_IDLE | walker free, accepts rel_req
//   S_WALK | returning one page per cycle, following the link memory
module page_linker #(
  parameter int PAGE_W  = 11,
  parameter int RESERVE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  page_linker_if.slave bus
);
  localparam int NPAGES = 1 << PAGE_W;
  localparam logic [PAGE_W:0] FREE_INIT = (PAGE_W+1)'(NPAGES);
  localparam logic [PAGE_W:0] RSV       = (PAGE_W+1)'(RESERVE);
  localparam logic [PAGE_W:0] ONE       = (PAGE_W+1)'(1);

  typedef enum logic {S_IDLE, S_WALK} walk_state_e;

  logic              in_pkt_q;
  logic [PAGE_W-1:0] prev_page_q;
  logic [PAGE_W-1:0] head_pg_q;
  logic [PAGE_W:0]   cnt_q;
  logic              pkt_valid_q;
  logic [PAGE_W-1:0] pkt_head_q;
  logic [PAGE_W:0]   pkt_len_q;
  logic              proto_err_q;

  walk_state_e       state_q;
  logic [PAGE_W-1:0] cur_q, cur_d;
  logic [PAGE_W:0]   rem_q;
  logic              rel_done_q;
  logic [PAGE_W-1:0] link_rd_q;

  logic [PAGE_W:0]   free_cnt_q;

  logic [PAGE_W-1:0] link_mem [0:NPAGES-1];

  logic legal, grant, link_we, push;

  assign legal   = in_pkt_q ? ~bus.wr_sop : bus.wr_sop;
  assign grant   = bus.wr_req & (free_cnt_q > RSV) & legal;
  assign link_we = grant & ~bus.wr_sop;
  assign push    = (state_q == S_WALK);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      in_pkt_q    <= 1'b0;
      prev_page_q <= '0;
      head_pg_q   <= '0;
      cnt_q       <= '0;
      pkt_valid_q <= 1'b0;
      pkt_head_q  <= '0;
      pkt_len_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      pkt_valid_q <= 1'b0;
      proto_err_q <= bus.wr_req & ~legal;
      if (grant) begin
        prev_page_q <= bus.head_addr;
        if (bus.wr_sop) begin
          head_pg_q <= bus.head_addr;
          cnt_q     <= ONE;
          in_pkt_q  <= ~bus.wr_eop;
          if (bus.wr_eop) begin
            pkt_valid_q <= 1'b1;
            pkt_head_q  <= bus.head_addr;
            pkt_len_q   <= ONE;
          end
        end else begin
          cnt_q <= cnt_q + ONE;
          if (bus.wr_eop) begin
            in_pkt_q    <= 1'b0;
            pkt_valid_q <= 1'b1;
            pkt_head_q  <= head_pg_q;
            pkt_len_q   <= cnt_q + ONE;
          end
        end
      end
    end
  end

  // Read address is the next cur, so link_rd_q already holds link[cur_q] in WALK.
  always_comb begin
    cur_d = cur_q;
    if (state_q == S_IDLE) begin
      if (bus.rel_req && (bus.rel_pages != '0)) cur_d = bus.rel_head;
    end else begin
      cur_d = link_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (link_we) link_mem[prev_page_q] <= bus.head_addr;
    link_rd_q <= link_mem[cur_d];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      rem_q      <= '0;
      rel_done_q <= 1'b0;
    end else begin
      rel_done_q <= 1'b0;
      cur_q      <= cur_d;
      case (state_q)
        S_IDLE: begin
          if (bus.rel_req) begin
            if (bus.rel_pages == '0) begin
              rel_done_q <= 1'b1;
            end else begin
              rem_q   <= bus.rel_pages;
              state_q <= S_WALK;
            end
          end
        end
        S_WALK: begin
          rem_q <= rem_q - ONE;
          if (rem_q == ONE) begin
            state_q    <= S_IDLE;
            rel_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      free_cnt_q <= FREE_INIT;
    end else begin
      case ({push, grant})
        2'b10:   free_cnt_q <= free_cnt_q + ONE;
        2'b01:   free_cnt_q <= free_cnt_q - ONE;
        default: free_cnt_q <= free_cnt_q;
      endcase
    end
  end

  assign bus.wr_ack    = grant;
  assign bus.wr_page   = bus.head_addr;
  assign bus.pop_head  = grant;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_head  = pkt_head_q;
  assign bus.pkt_len   = pkt_len_q;
  assign bus.proto_err = proto_err_q;
  assign bus.rel_ready = (state_q == S_IDLE);
  assign bus.rel_done  = rel_done_q;
  assign bus.push_tail = push;
  assign bus.tail_addr = cur_q;
  assign bus.free_cnt  = free_cnt_q;
endmodule

// File: tb/tb_page_linker.sv
// Bench for page_linker: a queue-based model of the free list, open packet,
// closed packets and release walk predicts every output each cycle.
module tb_page_linker;
  localparam int PW  = 11;
  localparam int NP  = 1 << PW;
  localparam int RSV = 2;

  typedef struct {
    int req, sop, eop, rrq, rhead, rpages;
    int e_ack, e_page, e_pv, e_head, e_len, e_err, e_ready, e_push, e_tail, e_done, e_free;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  page_linker_if #(.PAGE_W(PW)) bus ();
  page_linker #(.PAGE_W(PW), .RESERVE(RSV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int fifo[$], cur_pg[$], done_pg[$], done_len[$], done_head[$], walk[$];
  bit m_in_pkt, m_busy, p_valid, p_err, p_done;
  int p_head, p_len;
  vec_t tv[21];
  int tab_i = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo.delete(); cur_pg.delete(); done_pg.delete();
    done_len.delete(); done_head.delete(); walk.delete();
    for (int i = 0; i < NP; i++) fifo.push_back(i);
    m_in_pkt = 0; m_busy = 0; p_valid = 0; p_err = 0; p_done = 0;
    p_head = 0; p_len = 0;
  endtask

  task automatic cycle(input int rst, input int req, input int sop, input int eop,
                       input int rrq, input int rhead, input int rpages);
    bit legal, e_ack;
    int pg, n;
    vec_t v;
    @(negedge clk);
    rst_n         = (rst != 0);
    bus.wr_req    = (req != 0);
    bus.wr_sop    = (sop != 0);
    bus.wr_eop    = (eop != 0);
    bus.rel_req   = (rrq != 0);
    bus.rel_head  = PW'(rhead);
    bus.rel_pages = (PW+1)'(rpages);
    bus.head_addr = (fifo.size() > 0) ? PW'(fifo[0]) : '0;
    #1;
    legal = m_in_pkt ? (sop == 0) : (sop != 0);
    e_ack = (req != 0) && legal && (fifo.size() > RSV);
    if (rst == 0) begin
      chk("wr_ack", int'(bus.wr_ack), int'(e_ack));
      chk("pop_head", int'(bus.pop_head), int'(e_ack));
      if (e_ack) chk("wr_page", int'(bus.wr_page), fifo[0]);
      chk("pkt_valid", int'(bus.pkt_valid), int'(p_valid));
      if (p_valid) begin
        chk("pkt_head", int'(bus.pkt_head), p_head);
        chk("pkt_len", int'(bus.pkt_len), p_len);
      end
      chk("proto_err", int'(bus.proto_err), int'(p_err));
      chk("rel_ready", int'(bus.rel_ready), int'(!m_busy));
      chk("push_tail", int'(bus.push_tail), int'(m_busy));
      if (m_busy) chk("tail_addr", int'(bus.tail_addr), walk[0]);
      chk("rel_done", int'(bus.rel_done), int'(p_done));
      chk("free_cnt", int'(bus.free_cnt), fifo.size());
      if (tab_i >= 0) begin
        v = tv[tab_i];
        chk($sformatf("tab%0d_ack", tab_i), int'(bus.wr_ack), v.e_ack);
        if (v.e_ack != 0) chk($sformatf("tab%0d_page", tab_i), int'(bus.wr_page), v.e_page);
        chk($sformatf("tab%0d_pv", tab_i), int'(bus.pkt_valid), v.e_pv);
        if (v.e_pv != 0) begin
          chk($sformatf("tab%0d_head", tab_i), int'(bus.pkt_head), v.e_head);
          chk($sformatf("tab%0d_len", tab_i), int'(bus.pkt_len), v.e_len);
        end
        chk($sformatf("tab%0d_err", tab_i), int'(bus.proto_err), v.e_err);
        chk($sformatf("tab%0d_ready", tab_i), int'(bus.rel_ready), v.e_ready);
        chk($sformatf("tab%0d_push", tab_i), int'(bus.push_tail), v.e_push);
        if (v.e_push != 0) chk($sformatf("tab%0d_tail", tab_i), int'(bus.tail_addr), v.e_tail);
        chk($sformatf("tab%0d_done", tab_i), int'(bus.rel_done), v.e_done);
        chk($sformatf("tab%0d_free", tab_i), int'(bus.free_cnt), v.e_free);
      end
    end
    @(posedge clk);
    if (rst != 0) begin
      model_reset();
    end else begin
      p_err   = (req != 0) && !legal;
      p_valid = 0;
      if (e_ack) begin
        pg = fifo.pop_front();
        if (sop != 0) begin
          cur_pg.delete();
          m_in_pkt = (eop == 0);
        end
        cur_pg.push_back(pg);
        if (eop != 0) begin
          m_in_pkt = 0;
          p_valid  = 1;
          p_head   = cur_pg[0];
          p_len    = cur_pg.size();
          done_head.push_back(p_head);
          done_len.push_back(p_len);
          foreach (cur_pg[i]) done_pg.push_back(cur_pg[i]);
          cur_pg.delete();
        end
      end
      p_done = 0;
      if (m_busy) begin
        fifo.push_back(walk.pop_front());
        if (walk.size() == 0) begin
          m_busy = 0;
          p_done = 1;
        end
      end else if (rrq != 0) begin
        if (rpages == 0) begin
          p_done = 1;
        end else if (done_len.size() > 0) begin
          n = done_len.pop_front();
          void'(done_head.pop_front());
          for (int i = 0; i < n; i++) walk.push_back(done_pg.pop_front());
          m_busy = 1;
        end
      end
    end
  endtask

  initial begin
    bus.wr_req = 1'b0; bus.wr_sop = 1'b0; bus.wr_eop = 1'b0;
    bus.rel_req = 1'b0; bus.rel_head = '0; bus.rel_pages = '0; bus.head_addr = '0;
    model_reset();

    //          req sop eop rrq rh rp | ack pg pv hd len err rdy psh tl dn free
    tv[0]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2048};
    tv[1]  = '{1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2048};
    tv[2]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 2047};
    tv[3]  = '{1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2047};
    tv[4]  = '{1, 0, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 2046};
    tv[5]  = '{1, 0, 1, 0, 0, 0,  1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 2045};
    tv[6]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 3, 0, 1, 0, 0, 0, 2044};
    tv[7]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2044};
    tv[8]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2044};
    tv[9]  = '{1, 1, 0, 0, 0, 0,  1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 2044};
    tv[10] = '{1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2043};
    tv[11] = '{1, 0, 1, 0, 0, 0,  1, 5, 0, 0, 0, 1, 1, 0, 0, 0, 2043};
    tv[12] = '{0, 0, 0, 1, 0, 1,  0, 0, 1, 4, 2, 0, 1, 0, 0, 0, 2042};
    tv[13] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2042};
    tv[14] = '{0, 0, 0, 1, 1, 3,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2043};
    tv[15] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2043};
    tv[16] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2044};
    tv[17] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 2045};
    tv[18] = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2046};
    tv[19] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2046};
    tv[20] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2046};

    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_pkt_head", int'(bus.pkt_head), 0);
    chk("rst_pkt_len", int'(bus.pkt_len), 0);
    chk("rst_tail_addr", int'(bus.tail_addr), 0);
    chk("rst_free_cnt", int'(bus.free_cnt), NP);

    for (int i = 0; i < 21; i++) begin
      tab_i = i;
      cycle(0, tv[i].req, tv[i].sop, tv[i].eop, tv[i].rrq, tv[i].rhead, tv[i].rpages);
    end
    tab_i = -1;

    // Reset while walking the remaining packet {4,5}.
    cycle(0, 0, 0, 0, 1, 4, 2);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rstwalk_push", int'(bus.push_tail), 0);
    chk("rstwalk_ready", int'(bus.rel_ready), 1);
    chk("rstwalk_free", int'(bus.free_cnt), NP);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Reserve limit: one single-page packet plus 2045 pages of an open one.
    cycle(0, 1, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2044; i++) cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("rsv_free_at_limit", int'(bus.free_cnt), RSV);
    chk("rsv_stall_ack", int'(bus.wr_ack), 0);
    cycle(0, 1, 0, 0, 1, 0, 1);
    #1;
    chk("rsv_free_before_push", int'(bus.free_cnt), RSV);
    chk("rsv_still_stalled", int'(bus.wr_ack), 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("rsv_free_restored", int'(bus.free_cnt), RSV + 1);
    chk("rsv_ack_resumes", int'(bus.wr_ack), 1);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Randomised mixed traffic with overlapping writes and releases.
    for (int c = 0; c < 3000; c++) begin
      int req, sop, eop, rrq, rh, rp;
      req = int'($urandom_range(0, 9) < 7);
      sop = m_in_pkt ? int'($urandom_range(0, 19) == 0) : int'($urandom_range(0, 19) != 0);
      eop = int'($urandom_range(0, 4) == 0);
      rrq = 0; rh = 0; rp = 0;
      if (!m_busy && done_len.size() > 0 && $urandom_range(0, 3) == 0) begin
        rrq = 1; rh = done_head[0]; rp = done_len[0];
      end else if (!m_busy && $urandom_range(0, 59) == 0) begin
        rrq = 1; rh = int'($urandom_range(0, NP - 1)); rp = 0;
      end
      cycle(0, req, sop, eop, rrq, rh, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/page_linker.md
# page_linker

Page allocation and reclamation engine for the shared packet buffer. It takes free pages from the null-page FIFO, one per write beat, to build a singly linked page chain per packet. It reports each finished packet's head page and length to the queue manager. On release, it walks a packet's chain and returns every page to the null-page FIFO.

## Interface
Parameters:
- `PAGE_W`, 11: page address width (2048 pages)
- `RESERVE`, 2: pages held back; allocation is granted only while `free_cnt > RESERVE`

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous reset, active-high: 1 on a `clk` edge resets the block
- `wr_req`  in  1  request one page for the current write beat
- `wr_sop`  in  1  first page of a packet (qualified by `wr_req`)
- `wr_eop`  in  1  last page of a packet (qualified by `wr_req`)
- `wr_ack`  out  1  page granted this cycle (combinational)
- `wr_page`  out  PAGE_W  granted page, valid with `wr_ack`
- `pkt_valid`  out  1  one-cycle pulse: packet chain closed
- `pkt_head`  out  PAGE_W  head page of the closed packet
- `pkt_len`  out  PAGE_W+1  number of pages in the closed packet
- `proto_err`  out  1  one-cycle pulse: SOP/EOP protocol violation
- `rel_req`  in  1  release request
- `rel_head`  in  PAGE_W  head page of the chain to release
- `rel_pages`  in  PAGE_W+1  page count of the chain
- `rel_ready`  out  1  walker idle, can accept `rel_req`
- `rel_done`  out  1  one-cycle pulse: release finished
- `pop_head`  out  1  to null-page FIFO: consume `head_addr`
- `head_addr`  in  PAGE_W  from null-page FIFO: current free page
- `push_tail`  out  1  to null-page FIFO: return `tail_addr`
- `tail_addr`  out  PAGE_W  page being returned
- `free_cnt`  out  PAGE_W+1  free pages currently in the FIFO

## Operation
- **Link memory:** `link[0:2^PAGE_W-1]`, PAGE_W wide, 1 write port and 1 registered read port. It has no reset, and unwritten entries are don't-care.
- **Packet tracking:** the writer keeps `in_pkt`, `prev_page`, `head_pg` and `cnt`.
- **Grant condition:** `wr_ack = wr_req & (free_cnt > RESERVE) & legal`.
  - `legal` is `wr_sop` when `!in_pkt`, and `!wr_sop` when `in_pkt`.
  - `pop_head = wr_ack`.
  - `wr_page = head_addr`.
- **Protocol violation:** an illegal `wr_req` gets no ack, no pop and no state change. `proto_err` pulses on the next cycle.
- **On an ack with SOP:**
  - `head_pg <= page`, `cnt <= 1`, `prev_page <= page`.
  - `in_pkt <= !wr_eop`.
- **On an ack without SOP:**
  - `link[prev_page] <= page`, `prev_page <= page`, `cnt <= cnt+1`.
- **On an ack with EOP:**
  - Next cycle, `pkt_valid = 1`, `pkt_head = head_pg` and `pkt_len` is the final count.
  - `in_pkt <= 0`.
  - A SOP+EOP beat gives `pkt_len = 1` and writes no link.
- **Walker FSM:**
  - IDLE: `rel_ready = 1`. When `rel_req` is high:
    - If `rel_pages == 0`, stay in IDLE and pulse `rel_done` next cycle.
    - Otherwise set `cur <= rel_head`, `rem <= rel_pages` and go to WALK.
  - WALK: `push_tail = 1`, `tail_addr = cur`, `cur <= link[cur]` (registered read), `rem <= rem-1`. When `rem == 1`, go to IDLE and pulse `rel_done` next cycle.
- **Free count:**
  - Reset value is 2048.
  - `+1` on `push_tail`, `-1` on `pop_head`; both in the same cycle leaves it unchanged.
  - The `RESERVE` guard prevents popping a page pushed in the same or the previous cycle, covering the FIFO's write-to-read hazard.
- **Concurrency:** the writer and walker run concurrently. A link write and a walker read never target the same page, because an open packet's pages are never released.

## Timing
- Reset values:
  - `wr_ack`, `pkt_valid`, `proto_err`, `rel_done`, `pop_head`, `push_tail` = 0.
  - `pkt_head`, `pkt_len`, `tail_addr` = 0.
  - `rel_ready` = 1, `free_cnt` = 2048, `in_pkt` = 0, FSM = IDLE.
- A reset mid-packet or mid-walk drops all state. The FIFO is reset alongside and re-initialises its page list.
- Grant latency is 0 cycles, so one page can be granted per cycle.
- `pkt_valid` follows the EOP ack by 1 cycle.
- Release of N ≥ 1 pages:
  - Accepted at cycle t.
  - Pushes in cycles t+1 … t+N.
  - `rel_done` and `rel_ready` are high at t+N+1.
- `free_cnt` updates on the edge after the pop/push cycle.

## Test plan
- **Single-page packet:** after reset, `wr_req`+`sop`+`eop` → `wr_ack` with `wr_page = 0`, then `pkt_valid` with head 0, len 1. `free_cnt` = 2047.
- **Three-page packet, then release:**
  - Write pages 0, 1, 2 → `link[0] = 1` and `link[1] = 2`; `pkt_len = 3`.
  - Release (head 0, 3 pages) → `push_tail` with 0, 1, 2 on 3 consecutive cycles.
  - `rel_done` follows; `free_cnt` returns to 2048.
- **Protocol errors:**
  - Non-SOP `wr_req` while idle → no ack, `proto_err` pulses.
  - SOP while `in_pkt` → no ack, `proto_err` pulses, open packet unaffected.
- **Reserve limit:** allocate 2046 pages back-to-back → the 2047th request is not acked while `free_cnt` = 2. It is acked only after a release restores `free_cnt` to 3 or more.
- **Concurrent traffic:** write a new packet and release an old one in overlapping cycles → `free_cnt` is unchanged on cycles with both a pop and a push. Chains stay intact.
- **Reset mid-walk:** `rst_n` = 1 during WALK → next cycle `push_tail` = 0, `rel_ready` = 1, `free_cnt` = 2048.
